// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, muldiv FSM states and flag bit positions shared by alu_seq_n.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ROR = 4'b0010;
  localparam logic [3:0] OP_ROL = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic is_iter(input logic [3:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/alu_seq_n_if.sv
// alu_seq_n_if: start/done request bus between the control unit and alu_seq_n; ALU_FLAGS_EN adds out_flags.
interface alu_seq_n_if #(parameter int WIDTH = 32);
  logic in_start;
  logic [3:0] in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic out_busy;
  logic out_done;
  logic out_div_zero;
  logic [2*WIDTH-1:0] out_result;
`ifdef ALU_FLAGS_EN
  logic [3:0] out_flags;
  modport master(output in_start, in_opcode, in_a, in_b,
                 input out_busy, out_done, out_div_zero, out_result, out_flags);
  modport slave(input in_start, in_opcode, in_a, in_b,
                output out_busy, out_done, out_div_zero, out_result, out_flags);
`else
  modport master(output in_start, in_opcode, in_a, in_b,
                 input out_busy, out_done, out_div_zero, out_result);
  modport slave(input in_start, in_opcode, in_a, in_b,
                output out_busy, out_done, out_div_zero, out_result);
`endif
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: signed shift-add multiplier / restoring divider, one bit per CALC cycle; ALU_FLAGS_EN adds flags.
module muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               idle,
  output logic               fin,
  output logic [2*WIDTH-1:0] res,
  output logic               dz
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]         flags
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, sn, sn_r, zdiv;
  logic [WIDTH-1:0] ra, rb, abs_a, abs_b, m, q, r;
  logic [WIDTH:0] mac, rs, rd;
  logic [2*WIDTH-1:0] p, p_nx;
  assign abs_a = ra[WIDTH-1] ? -ra : ra;
  assign abs_b = rb[WIDTH-1] ? -rb : rb;
  // p holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mac = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
  assign rs = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign rd = rs - {1'b0, m};
  assign p_nx = is_div ? {(rd[WIDTH] ? rs[WIDTH-1:0] : rd[WIDTH-1:0]), p[WIDTH-2:0], !rd[WIDTH]}
                       : {mac, p[WIDTH-1:1]};
  assign q = p_nx[WIDTH-1:0];
  assign r = p_nx[2*WIDTH-1:WIDTH];
  // sign correction is folded into the last CALC step so the result lands as FIX begins
  assign res = zdiv ? {ra, {WIDTH{1'b1}}}
             : !is_div ? (sn ? -p_nx : p_nx)
             : {(sn_r ? -r : r), (sn ? -q : q)};
  assign idle = state == IDLE;
  assign fin = state == CALC && cnt == CW'(1);
  assign dz = zdiv;
`ifdef ALU_FLAGS_EN
  always_comb begin
    flags = '0;
    flags[FLAG_N] = is_div ? res[WIDTH-1] : res[2*WIDTH-1];
    flags[FLAG_Z] = is_div ? res[WIDTH-1:0] == '0 : res == '0;
    flags[FLAG_V] = is_div && !zdiv && ra == {1'b1, {(WIDTH-1){1'b0}}} && rb == '1;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      sn <= 1'b0;
      sn_r <= 1'b0;
      zdiv <= 1'b0;
      ra <= '0;
      rb <= '0;
      m <= '0;
      p <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= b;
          is_div <= div;
          state <= PREP;
        end
        PREP: begin
          m <= is_div ? abs_b : abs_a;
          p <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
          sn <= ra[WIDTH-1] ^ rb[WIDTH-1];
          sn_r <= ra[WIDTH-1];
          zdiv <= is_div && rb == '0;
          cnt <= CW'(WIDTH);
          state <= CALC;
        end
        CALC: begin
          p <= zdiv ? p : p_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: registered ALU, 1-cycle ops inline plus iterative MUL/DIV; ALU_FLAGS_EN adds out_flags {N,Z,C,V}.
module alu_seq_n import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic        in_clk,
  input logic        in_rst_n,
  alu_seq_n_if.slave bus
);
  logic [3:0] op;
  logic [WIDTH-1:0] a, b, x, y, s, lo;
  logic [SHAMT_W-1:0] sh, nsh;
  logic [2*WIDTH-1:0] fin_res;
  logic arith, accept, md_go, one, md_idle, fin, fin_dz;
  assign op = bus.in_opcode;
  assign a = bus.in_a;
  assign b = bus.in_b;
  assign sh = b[SHAMT_W-1:0];
  assign nsh = -sh;
  // ADD/SUB/NEG share one adder: x + y + cin with NEG as 0 - a
  assign arith = op == OP_ADD || op == OP_SUB || op == OP_NEG;
  assign x = op == OP_NEG ? '0 : a;
  assign y = op == OP_ADD ? b : op == OP_SUB ? ~b : ~a;
`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] cs;
  logic [3:0] f1, fin_flags;
  assign cs = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(op != OP_ADD);
  assign s = cs[WIDTH-1:0];
  always_comb begin
    f1 = '0;
    f1[FLAG_N] = lo[WIDTH-1];
    f1[FLAG_Z] = lo == '0;
    f1[FLAG_C] = arith && cs[WIDTH];
    f1[FLAG_V] = arith && x[WIDTH-1] == y[WIDTH-1] && s[WIDTH-1] != x[WIDTH-1];
  end
`else
  assign s = x + y + WIDTH'(op != OP_ADD);
`endif
  assign lo = arith ? s
            : op == OP_ROR ? (a >> sh) | (a << nsh)
            : op == OP_ROL ? (a << sh) | (a >> nsh)
            : op == OP_SHR ? a >> sh
            : op == OP_SHL ? a << sh
            : op == OP_AND ? a & b
            : op == OP_OR  ? a | b
            : op == OP_NOT ? ~a
            : '0;
  assign accept = bus.in_start && !bus.out_busy && md_idle;
  assign md_go = accept && is_iter(op);
  assign one = accept && !is_iter(op);
  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .start (md_go),
    .div   (op == OP_DIV),
    .a     (a),
    .b     (b),
    .idle  (md_idle),
    .fin   (fin),
    .res   (fin_res),
    .dz    (fin_dz)
`ifdef ALU_FLAGS_EN
    ,
    .flags (fin_flags)
`endif
  );
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      bus.out_busy <= 1'b0;
      bus.out_done <= 1'b0;
      bus.out_div_zero <= 1'b0;
      bus.out_result <= '0;
`ifdef ALU_FLAGS_EN
      bus.out_flags <= '0;
`endif
    end else begin
      bus.out_done <= fin || one;
      bus.out_busy <= md_go || (bus.out_busy && !fin);
      if (fin || one) begin
        bus.out_result <= fin ? fin_res : {{WIDTH{1'b0}}, lo};
        bus.out_div_zero <= fin && fin_dz;
`ifdef ALU_FLAGS_EN
        bus.out_flags <= fin ? fin_flags : f1;
`endif
      end
    end
endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed and randomized checks of alu_seq_n (WIDTH=32) against a longint reference model.
module tb_alu_seq_n;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  alu_seq_n_if #(.WIDTH(32)) bus();
  alu_seq_n #(.WIDTH(32)) dut (.in_clk(clk), .in_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] r, output logic dz, output int lat);
    longint sa, sb, qq, rr;
    int n;
    logic [31:0] t;
    sa = $signed(a);
    sb = $signed(b);
    n = int'(b[4:0]);
    t = '0;
    r = '0;
    dz = 1'b0;
    lat = 1;
    case (op)
      OP_ADD: r = {32'h0, a + b};
      OP_SUB: r = {32'h0, a - b};
      OP_ROR: begin
        for (int i = 0; i < 32; i++) t[i] = a[(i + n) % 32];
        r = {32'h0, t};
      end
      OP_ROL: begin
        for (int i = 0; i < 32; i++) t[(i + n) % 32] = a[i];
        r = {32'h0, t};
      end
      OP_SHR: r = {32'h0, a >> n};
      OP_SHL: r = {32'h0, a << n};
      OP_AND: r = {32'h0, a & b};
      OP_OR:  r = {32'h0, a | b};
      OP_NEG: r = {32'h0, -a};
      OP_NOT: r = {32'h0, ~a};
      OP_MUL: begin
        r = sa * sb;
        lat = 34;
      end
      OP_DIV: begin
        lat = 34;
        if (b == 0) begin
          r = {a, 32'hFFFFFFFF};
          dz = 1'b1;
        end else begin
          qq = sa / sb;
          rr = sa % sb;
          r = {rr[31:0], qq[31:0]};
        end
      end
      default: r = '0;
    endcase
  endfunction

  function automatic logic [3:0] fmodel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] r);
    longint sa, sb, v;
    logic [32:0] t33;
    logic n, z, c, ov;
    sa = $signed(a);
    sb = $signed(b);
    n = op == OP_MUL ? r[63] : r[31];
    z = op == OP_MUL ? r == 64'h0 : r[31:0] == 32'h0;
    c = 1'b0;
    ov = 1'b0;
    if (op == OP_ADD) begin
      t33 = {1'b0, a} + {1'b0, b};
      c = t33[32];
      v = sa + sb;
      ov = v > 64'sd2147483647 || v < -64'sd2147483648;
    end else if (op == OP_SUB) begin
      c = a >= b;
      v = sa - sb;
      ov = v > 64'sd2147483647 || v < -64'sd2147483648;
    end else if (op == OP_NEG) begin
      c = a == 32'h0;
      ov = a == 32'h80000000;
    end else if (op == OP_DIV) begin
      ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
    end
    return {n, z, c, ov};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op after an idle cycle, scrambles inputs, then waits (bounded) for done.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy);
    tick();
    bus.in_opcode = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    bus.in_a = $urandom;
    bus.in_b = $urandom;
    bus.in_opcode = 4'($urandom);
    lat = 1;
    nbusy = 0;
    while (!bus.out_done && lat < 100) begin
      nbusy += int'(bus.out_busy);
      tick();
      lat++;
    end
    if (!bus.out_done) lat = -1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.out_busy !== 1'b0 || bus.out_done !== 1'b0 || bus.out_div_zero !== 1'b0 || bus.out_result !== 64'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b result=%h, want all 0", bus.out_busy, bus.out_done,
               bus.out_div_zero, bus.out_result);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (bus.out_flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags: got %h want 0", bus.out_flags);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_one_cycle();
    logic [3:0] ops[7] = '{OP_ADD, OP_SUB, OP_NEG, OP_NOT, OP_AND, OP_OR, 4'b1100};
    logic [31:0] as[7] = '{32'h0000FFFF, 32'h0000FFFF, 32'h00000001, 32'hF0F0F0F0, 32'hF0F0FF00, 32'hF0F0FF00, 32'h12345678};
    logic [31:0] bs[7] = '{32'h00000001, 32'h000000FF, 32'h0, 32'h0, 32'h0FF0F0F0, 32'h0FF0F0F0, 32'h9ABCDEF0};
    logic [31:0] ex[7] = '{32'h00010000, 32'h0000FF00, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00F0F000, 32'hFFF0FFF0, 32'h0};
    int lat, nb;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], lat, nb);
      checks++;
      if (lat !== 1 || nb !== 0 || bus.out_busy !== 1'b0) begin
        errors++;
        $display("FAIL one_cycle_lat[%0d]: lat=%0d busy_cycles=%0d, want 1/0", i, lat, nb);
      end
      checks++;
      if (bus.out_result !== {32'h0, ex[i]}) begin
        errors++;
        $display("FAIL one_cycle_res[%0d]: got %h want %h", i, bus.out_result, {32'h0, ex[i]});
      end
    end
    tick();
    checks++;
    if (bus.out_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b one cycle after, want 0", bus.out_done);
    end
  endtask

  task automatic test_shift();
    logic [3:0] ops[4] = '{OP_ROL, OP_SHR, OP_SHL, OP_ROR};
    logic [31:0] bs[4] = '{32'h00000021, 32'h1, 32'h0, 32'hFFFFFFE4};
    logic [31:0] ex[4] = '{32'h00000003, 32'h40000000, 32'h80000001, 32'h18000000};
    int lat, nb;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'h80000001, bs[i], lat, nb);
      checks++;
      if (lat !== 1 || bus.out_result !== {32'h0, ex[i]}) begin
        errors++;
        $display("FAIL shift[%0d]: lat=%0d result=%h, want 1/%h", i, lat, bus.out_result, {32'h0, ex[i]});
      end
    end
  endtask

  task automatic test_mul();
    int lat, nb;
    tick();
    bus.in_opcode = OP_MUL;
    bus.in_a = 32'hFFFFFFF3;
    bus.in_b = 32'h0000000B;
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    bus.in_opcode = OP_ADD;
    bus.in_a = 32'h1;
    bus.in_b = 32'h1;
    lat = 1;
    nb = 0;
    while (!bus.out_done && lat < 100) begin
      nb += int'(bus.out_busy);
      bus.in_start = lat == 10;
      tick();
      lat++;
    end
    bus.in_start = 1'b0;
    checks++;
    if (lat !== 34 || nb !== 33 || bus.out_busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_timing: lat=%0d busy_cycles=%0d busy_at_done=%b, want 34/33/0", lat, nb, bus.out_busy);
    end
    checks++;
    if (bus.out_result !== 64'hFFFFFFFF_FFFFFF71 || bus.out_div_zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_res: got %h dz=%b want ffffffffffffff71/0", bus.out_result, bus.out_div_zero);
    end
    tick();
    checks++;
    if (bus.out_done !== 1'b0 || bus.out_result !== 64'hFFFFFFFF_FFFFFF71) begin
      errors++;
      $display("FAIL mul_hold: done=%b result=%h, want 0/ffffffffffffff71", bus.out_done, bus.out_result);
    end
  endtask

  task automatic test_div();
    logic [31:0] as[4] = '{32'h0000000A, 32'h0000000A, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] bs[4] = '{32'hFFFFFFFD, 32'h0, 32'hFFFFFFFF, 32'h2};
    logic [63:0] ex[4] = '{64'h00000001_FFFFFFFD, 64'h0000000A_FFFFFFFF, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFFFD};
    logic exz[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat, nb;
    for (int i = 0; i < 4; i++) begin
      run_op(OP_DIV, as[i], bs[i], lat, nb);
      checks++;
      if (lat !== 34 || bus.out_result !== ex[i] || bus.out_div_zero !== exz[i]) begin
        errors++;
        $display("FAIL div[%0d]: lat=%0d result=%h dz=%b, want 34/%h/%b", i, lat, bus.out_result,
                 bus.out_div_zero, ex[i], exz[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int lat, ndone;
    tick();
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      bus.in_opcode = OP_ADD;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_start = 1'b1;
      tick();
      checks++;
      if (bus.out_done !== 1'b1 || bus.out_result !== {32'h0, a + b}) begin
        errors++;
        $display("FAIL b2b_add[%0d]: done=%b result=%h, want 1/%h", i, bus.out_done, bus.out_result, {32'h0, a + b});
      end
    end
    bus.in_opcode = OP_MUL;
    bus.in_a = 32'd3;
    bus.in_b = 32'd5;
    tick();
    bus.in_start = 1'b0;
    lat = 1;
    while (!bus.out_done && lat < 100) begin
      tick();
      lat++;
    end
    bus.in_a = 32'd7;
    bus.in_b = 32'd7;
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    checks++;
    if (lat !== 34 || bus.out_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_mul: lat=%0d busy_after=%b, want 34/0", lat, bus.out_busy);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      ndone += int'(bus.out_done);
      tick();
    end
    checks++;
    if (ndone !== 0 || bus.out_result !== 64'd15) begin
      errors++;
      $display("FAIL b2b_ignored: extra_dones=%0d result=%h, want 0/f", ndone, bus.out_result);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, ndone;
    tick();
    bus.in_opcode = OP_MUL;
    bus.in_a = 32'hFFFFFFF3;
    bus.in_b = 32'h0000000B;
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    for (int i = 1; i < 12; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_busy !== 1'b0 || bus.out_done !== 1'b0 || bus.out_div_zero !== 1'b0 || bus.out_result !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dz=%b result=%h, want all 0", bus.out_busy, bus.out_done,
               bus.out_div_zero, bus.out_result);
    end
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      ndone += int'(bus.out_done) + int'(bus.out_busy);
      tick();
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: done/busy cycles=%0d, want 0", ndone);
    end
    run_op(OP_ADD, 32'd2, 32'd3, lat, nb);
    checks++;
    if (lat !== 1 || bus.out_result !== 64'd5) begin
      errors++;
      $display("FAIL reset_mid_add: lat=%0d result=%h, want 1/5", lat, bus.out_result);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] er;
    logic ez;
    int el, lat, nb;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      model(op, a, b, er, ez, el);
      run_op(op, a, b, lat, nb);
      checks++;
      if (lat !== el || bus.out_result !== er || bus.out_div_zero !== ez) begin
        errors++;
        $display("FAIL rand[%0d] op=%h a=%h b=%h: lat=%0d result=%h dz=%b, want %0d/%h/%b", i, op, a, b,
                 lat, bus.out_result, bus.out_div_zero, el, er, ez);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (bus.out_flags !== fmodel(op, a, b, er)) begin
        errors++;
        $display("FAIL rand_flags[%0d] op=%h a=%h b=%h: got %h want %h", i, op, a, b, bus.out_flags,
                 fmodel(op, a, b, er));
      end
`endif
    end
  endtask

  initial begin
    bus.in_start = 1'b0;
    bus.in_opcode = 4'h0;
    bus.in_a = 32'h0;
    bus.in_b = 32'h0;
    test_reset();
    test_one_cycle();
    test_shift();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
- Parametrised, registered ALU that succeeds the combinational 32-bit ALU in the datapath.
- Keeps the same 4-bit opcode map.
- Single-cycle logic, add and shift ops return in 1 cycle.
- MUL and DIV run as iterative signed shift-add / restoring-divide engines over WIDTH cycles, so the array multiplier and divider drop off the critical path.
- Control unit drives it through a start/done handshake and stalls while out_busy is high.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Legal values: power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), number of in_b LSBs used as the shift/rotate amount.

Ports:
- in_clk  input  1  system clock, rising edge.
- in_rst_n  input  1  reset; asynchronous, active-low.
- in_start  input  1  one-cycle request; sampled only while out_busy=0.
- in_opcode  input  4  0000 add, 0001 sub, 0010 ror, 0011 rol, 0100 shr, 0101 shl, 0110 and, 0111 or, 1000 mul, 1001 div, 1010 neg, 1011 not.
- in_a  input  WIDTH  operand A; minuend / dividend / multiplicand.
- in_b  input  WIDTH  operand B; subtrahend / divisor / multiplier / shift amount.
- out_busy  output  1  high from the cycle after an accepted start until out_done.
- out_done  output  1  one-cycle pulse; out_result is valid from this cycle on.
- out_result  output  2*WIDTH  registered result; held until the next accepted start.
- out_div_zero  output  1  high with out_done when a DIV had in_b=0; held with the result.

Behaviour:
- Reset (async, in_rst_n=0): state IDLE; out_busy, out_done, out_div_zero, out_result, iteration counter and all internal registers go to 0.
- Operand capture: on an accepted start, in_a, in_b and in_opcode are registered. Later input changes have no effect on the operation in flight.
- FSM IDLE: start with a 1-cycle opcode -> compute, register the result, pulse out_done next cycle, stay in IDLE. out_busy never rises.
- FSM IDLE: start with MUL/DIV -> PREP.
- FSM PREP (1 cycle): take abs of both operands, record result sign(s), load the counter with WIDTH -> CALC.
- FSM CALC (WIDTH cycles): one partial product or one restoring-divide step per cycle; the counter decrements; at 0 -> FIX.
- FSM FIX (1 cycle): apply sign correction, register out_result, pulse out_done -> IDLE.
- Latency: 1-cycle ops give out_done 1 cycle after start. MUL/DIV give out_done WIDTH+2 cycles after start (34 at WIDTH=32).
- Back-to-back: a start in the same cycle as out_done is ignored for MUL/DIV. For 1-cycle ops a start is accepted every cycle.
- Start while busy: ignored, no queueing.
- ADD/SUB/NEG: low WIDTH bits = modulo-2^WIDTH sum; upper half = 0. SUB = A-B. NEG = -A. NOT = ~A.
- AND/OR: bitwise; upper half = 0.
- Shifts: amount = in_b[SHAMT_W-1:0]; upper in_b bits ignored. SHR is logical. Amount 0 passes A through. Upper half = 0.
- MUL: signed two's-complement full 2*WIDTH product. Most-negative x most-negative is exact (2^(2W-2)).
- DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend. Result = {remainder, quotient}.
- DIV overflow: most-negative / -1 gives quotient = most-negative, remainder = 0.
- Divide by zero: bypasses CALC but keeps full latency. Quotient = all ones, remainder = in_a, out_div_zero = 1.
- Undefined opcodes (1100-1111): result 0, 1-cycle done.
- Reset mid-operation aborts immediately; no done pulse follows.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined: adds output out_flags[3:0] = {N, Z, C, V}, registered with out_result and reset to 0.
  - N and Z: evaluated on the low WIDTH bits, or on the full 2*WIDTH for MUL.
  - C: carry-out for ADD; for SUB and NEG it is the inverted borrow (1 = no borrow); 0 for all other ops.
  - V: signed overflow for ADD/SUB/NEG, and for DIV most-negative/-1; 0 otherwise.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds: opcode localparams (OP_ADD..OP_NOT), the FSM state enum {IDLE, PREP, CALC, FIX}, and flag bit indices.
- One sub-module, muldiv_iter: PREP/CALC/FIX datapath and counter with start/done.
- alu_seq_n keeps the 1-cycle logic, the handshake and the result mux.

Test Plan (WIDTH=32):
- ADD: a=0000FFFF, b=00000001, start -> next cycle done=1, result=00000000_00010000, busy never high.
- SUB/NEG: a=0000FFFF, b=000000FF -> 0000FF00. NEG a=00000001 -> FFFFFFFF. NOT a=F0F0F0F0 -> 0F0F0F0F.
- MUL: a=FFFFFFF3, b=0000000B -> busy 1 for cycles 1..33, done at cycle 34, result=FFFFFFFF_FFFFFF71. New start at cycle 10 ignored.
- DIV: a=0000000A, b=FFFFFFFD -> result {00000001, FFFFFFFD}. Then b=0 -> {0000000A, FFFFFFFF}, div_zero=1, done at cycle 34.
- Shifts: a=80000001. ROL b=00000021 -> 00000003. SHR b=1 -> 40000000. SHL b=0 -> 80000001.
- Reset mid-MUL (in_rst_n low at cycle 12): all outputs 0 immediately, no done. Next ADD works normally.
